// File: rtl/shift_seq_arbiter.sv
// shift_seq_arbiter: two requesters share a single one-position shifter.
// A round-robin arbiter picks one job in IDLE, the job is stepped once per
// clock in SHIFT until its count expires, and the result is held in DONE
// until the consumer takes it.

// One-position logical shifter. Sel[1] picks the operand (0 = A, 1 = B),
// Sel[0] picks the direction (0 = right, 1 = left). Vacated bits fill with
// zero; the sign bit is never replicated.
module Arithmetic_Shift_Top_Module #(
  parameter int Width = 4
) (
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  input  logic [1:0]       Sel,
  output logic [Width-1:0] out
);

  logic [Width-1:0] operand;

  // Operand select, then a single-step shift in the requested direction.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    operand = A;
    out     = '0;
    if (Sel[1]) operand = B;
    if (Sel[0]) out = {operand[Width-2:0], 1'b0};
    else        out = {1'b0, operand[Width-1:1]};
  end

endmodule

module shift_seq_arbiter #(
  parameter int Width     = 4,
  parameter int Amt_Width = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 Req0_Valid,
  output logic                 Req0_Ready,
  input  logic [Width-1:0]     Req0_Data,
  input  logic                 Req0_Dir,
  input  logic [Amt_Width-1:0] Req0_Amt,
  input  logic                 Req1_Valid,
  output logic                 Req1_Ready,
  input  logic [Width-1:0]     Req1_Data,
  input  logic                 Req1_Dir,
  input  logic [Amt_Width-1:0] Req1_Amt,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [Width-1:0]     Out_Data,
  output logic                 Out_Id,
  output logic                 Busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]           state;
  logic [Width-1:0]     work;       // working register, also the result
  logic [Amt_Width-1:0] count;      // remaining shift steps
  logic                 job_dir;
  logic                 job_id;
  logic                 last_id;    // requester granted most recently

  logic                 is_idle;
  logic                 grant_id;
  logic                 handshake;
  logic [Width-1:0]     sel_data;
  logic                 sel_dir;
  logic [Amt_Width-1:0] sel_amt;
  logic [Width-1:0]     shift_a;
  logic [Width-1:0]     shift_b;
  logic [Width-1:0]     shift_out;

  assign is_idle = (state == IDLE);

  // Round-robin pick: contention goes to whoever was not served last,
  // a lone valid requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (Req0_Valid && Req1_Valid) grant_id = ~last_id;
    else                          grant_id = Req1_Valid;
  end

  assign Req0_Ready = is_idle & Req0_Valid & ~grant_id;
  assign Req1_Ready = is_idle & Req1_Valid &  grant_id;
  assign handshake  = (Req0_Valid & Req0_Ready) | (Req1_Valid & Req1_Ready);

  // Job fields from whichever requester holds the grant.
  always_comb begin
    sel_data = Req0_Data;
    sel_dir  = Req0_Dir;
    sel_amt  = Req0_Amt;
    if (grant_id) begin
      sel_data = Req1_Data;
      sel_dir  = Req1_Dir;
      sel_amt  = Req1_Amt;
    end
  end

  // Requester 0 jobs ride on port A, requester 1 jobs on port B; the
  // unused port is tied to zero.
  assign shift_a = job_id ? '0   : work;
  assign shift_b = job_id ? work : '0;

  Arithmetic_Shift_Top_Module #(
    .Width (Width)
  ) u_shifter (
    .A   (shift_a),
    .B   (shift_b),
    .Sel ({job_id, job_dir}),
    .out (shift_out)
  );

  // Sequencer: accept a job in IDLE, step it in SHIFT, hold it in DONE.
  // NOTE: asynchronous active-low reset clears every state register so an
  // interrupted job is discarded and requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      work    <= '0;
      count   <= '0;
      job_dir <= 1'b0;
      job_id  <= 1'b0;
      last_id <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples values
      // from before the edge, independent of statement order.
      case (state)
        IDLE: begin
          if (handshake) begin
            work    <= sel_data;
            job_dir <= sel_dir;
            job_id  <= grant_id;
            last_id <= grant_id;
            count   <= sel_amt;
            if (sel_amt == '0) state <= DONE;
            else               state <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= shift_out;
          count <= count - 1'b1;
          if (count == Amt_Width'(1)) state <= DONE;
        end
        DONE: begin
          if (Out_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Out_Valid = (state == DONE);
  assign Out_Data  = work;
  assign Out_Id    = job_id;
  assign Busy      = ~is_idle;

endmodule

// File: doc/shift_seq_arbiter.md
SHIFT_SEQ_ARBITER -- requirements
Module: shift_seq_arbiter

Interface
REQ-001 Parameter: Width, 4, operand/result width.
REQ-002 Parameter: Amt_Width, 3, shift-amount width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: Req0_Valid  input  1  requester 0 has a shift job.
REQ-006 Port: Req0_Ready  output  1  requester 0 job accepted this cycle.
REQ-007 Port: Req0_Data  input  Width  requester 0 operand.
REQ-008 Port: Req0_Dir  input  1  requester 0 direction; 0 = right, 1 = left.
REQ-009 Port: Req0_Amt  input  Amt_Width  requester 0 shift count.
REQ-010 Port: Req1_Valid / Req1_Ready / Req1_Data / Req1_Dir / Req1_Amt  in/out/in/in/in  1/1/Width/1/Amt_Width  requester 1, same meaning as requester 0.
REQ-011 Port: Out_Valid  output  1  result available.
REQ-012 Port: Out_Ready  input  1  consumer accepts result.
REQ-013 Port: Out_Data  output  Width  shifted result.
REQ-014 Port: Out_Id  output  1  requester that owns Out_Data.
REQ-015 Port: Busy  output  1  high whenever FSM is not IDLE.

Function
REQ-016 Block SHALL instantiate the team's one-position shifter Arithmetic_Shift_Top_Module (A, B, Sel, out) as its only shift datapath, shared by both requesters.
REQ-017 Per-step operation SHALL be right: {0, x[Width-1:1]}, left: {x[Width-2:0], 0}, with no sign replication.
REQ-018 Requester 0 jobs SHALL drive the working register on A with B = 0, Sel = {0, Dir}; requester 1 jobs on B with A = 0, Sel = {1, Dir}.
REQ-019 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-020 In IDLE with any Valid high, the arbiter SHALL grant exactly one requester, round-robin: the requester not granted last wins when both are valid; a lone valid requester always wins.
REQ-021 Ready SHALL be combinational, high only for the granted requester and only in IDLE; handshake = Valid & Ready on a rising edge.
REQ-022 On handshake, block SHALL capture Data, Dir, Amt and requester id, and update last-granted.
REQ-023 On handshake with Amt = 0, next state SHALL be DONE with Out_Data = captured Data; otherwise next state SHALL be SHIFT with counter = Amt.
REQ-024 In SHIFT, each edge SHALL load the shifter output into the working register and decrement the counter; when the counter is 1, next state SHALL be DONE.
REQ-025 Latency: Out_Valid SHALL rise Amt+1 rising edges after the handshake edge (1 edge for Amt = 0).
REQ-026 Amt >= Width SHALL still execute Amt steps, yielding all zeros.
REQ-027 In DONE, Out_Valid SHALL be high and Out_Data/Out_Id stable until Out_Valid & Out_Ready on an edge, then next state SHALL be IDLE; no new job is accepted in that same cycle.
REQ-028 Requester inputs SHALL be ignored outside IDLE; a requester's Valid held across SHIFT/DONE SHALL be served at the next IDLE per round-robin.

Reset
REQ-029 While rst_n = 0, at any state, block SHALL go to IDLE immediately with Out_Valid = 0, Out_Data = 0, Out_Id = 0, Busy = 0, counter = 0, and last-granted = requester 1 so that requester 0 wins the first contention.
REQ-030 A job in SHIFT or DONE when reset asserts SHALL be discarded and never reported.

Verification
REQ-031 Req0 Data=1100, Dir=0, Amt=2 -> Req0_Ready high in IDLE; Out_Valid 3 edges later, Out_Data=0011, Out_Id=0.
REQ-032 Req1 Data=0011, Dir=1, Amt=3 -> Out_Data=1000, Out_Id=1 after 4 edges; Req1 Data=1111, Dir=0, Amt=7 -> Out_Data=0000 after 8 edges.
REQ-033 Req0 and Req1 both valid from reset release, Amt=0 -> req0 served first (Out_Id=0), then req1 (Out_Id=1); a second contention grants req0 again.
REQ-034 Out_Ready held low 5 cycles in DONE -> Out_Valid, Out_Data, Out_Id stable for all 5; Req0_Ready/Req1_Ready stay low; Busy stays high.
REQ-035 rst_n pulsed low mid-SHIFT (Amt=5, after 2 steps) -> all outputs 0 asynchronously, no result reported; next contention grants req0.
